fdc_sample_decimator: RTL and testbench

// - Sits directly downstream of the FDC measurement core inside tt_um_fdc_chip.
// - Consumes one raw count per completed FDC measurement window and averages
//   2^nsel consecutive samples, which reduces quantisation noise.
// - Presents the averaged result to the output mux through a valid/ack hold

---
 rtl/fdc_sample_decimator.sv | 123 ++++++++++++
 tb/tb_fdc_sample_decimator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fdc_sample_decimator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fdc_sample_decimator                                                     |
// | Block-averages 2^nsel raw FDC counts behind a valid/ack result register. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fdc_sample_decimator #(
    parameter int SW       = 8,
    parameter int MAX_LOG2 = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          smp_valid,
    input  logic [SW-1:0] smp_data,
    input  logic [2:0]    nsel,
    input  logic          res_ack,
    output logic [SW-1:0] res_data,
    output logic          res_valid,
    output logic          overrun,
    output logic          busy
);
    localparam int         AW         = SW + MAX_LOG2;
    localparam int         CW         = MAX_LOG2 + 1;
    localparam logic [2:0] c_MAX_NSEL = 3'(MAX_LOG2);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_n_lat;
    logic          r_ena_d;
    logic [SW-1:0] r_res_data;
    logic          r_res_valid;
    logic          r_overrun;
    logic          r_busy;

    logic [2:0]    w_nsel_clamped;
    logic [AW-1:0] w_sum;
    logic [SW-1:0] w_cand;
    logic          w_last;
    logic          w_done;

    assign w_nsel_clamped = (nsel > c_MAX_NSEL) ? c_MAX_NSEL : nsel;
    assign w_sum          = r_acc + AW'(smp_data);
    assign w_cand         = SW'(w_sum >> r_n_lat);
    assign w_last         = (r_cnt == CW'((32'd1 << r_n_lat) - 32'd1));
    // A partial block never completes once ena has dropped.
    assign w_done         = (r_state == S_ACC) && ena && smp_valid && w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_n_lat     <= '0;
            r_ena_d     <= 1'b0;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_ena_d <= ena;
            case (r_state)
                S_IDLE: begin
                    if (ena) begin
                        r_state <= S_ACC;
                        r_busy  <= 1'b1;
                        r_n_lat <= w_nsel_clamped;
                    end
                end
                S_ACC: begin
                    if (!ena) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end else if (smp_valid) begin
                        if (w_last) begin
                            // Restart immediately so back-to-back blocks lose no sample.
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_n_lat <= w_nsel_clamped;
                        end else begin
                            r_acc <= w_sum;
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            if (w_done) begin
                if (!r_res_valid || res_ack) begin
                    r_res_data  <= w_cand;
                    r_res_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (res_ack) begin
                r_res_valid <= 1'b0;
            end

            if (r_ena_d && !ena) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign res_data  = r_res_data;
    assign res_valid = r_res_valid;
    assign overrun   = r_overrun;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fdc_sample_decimator.sv
`default_nettype none
// Testbench for fdc_sample_decimator: vector table, directed corner cases,
// and random traffic against a block-averaging reference model.
module tb_fdc_sample_decimator;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       smp_valid;
    logic [7:0] smp_data;
    logic [2:0] nsel;
    logic       res_ack;
    logic [7:0] res_data;
    logic       res_valid;
    logic       overrun;
    logic       busy;

    fdc_sample_decimator #(.SW(8), .MAX_LOG2(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .smp_valid (smp_valid),
        .smp_data  (smp_data),
        .nsel      (nsel),
        .res_ack   (res_ack),
        .res_data  (res_data),
        .res_valid (res_valid),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: collects the samples of the current block in a queue
    // and averages them with plain integer arithmetic when the block is full.
    bit   m_active;
    int   m_n;
    int   m_q[$];
    int   m_data;
    bit   m_valid;
    bit   m_ovr;
    bit   m_ena_prev;

    function automatic int clamp(input int ns);
        return (ns > 4) ? 4 : ns;
    endfunction

    task automatic model_reset();
        m_active = 0; m_n = 0; m_q.delete();
        m_data = 0; m_valid = 0; m_ovr = 0; m_ena_prev = 0;
    endtask

    task automatic model_step(input bit e, input bit sv, input int d, input int ns, input bit ack);
        bit done = 0;
        int cand = 0;
        int sum  = 0;
        if (!m_active) begin
            if (e) begin
                m_active = 1;
                m_n = clamp(ns);
                m_q.delete();
            end
        end else if (!e) begin
            m_active = 0;
            m_q.delete();
        end else if (sv) begin
            m_q.push_back(d);
            if (m_q.size() == (1 << m_n)) begin
                foreach (m_q[i]) sum += m_q[i];
                cand = (sum / (2 ** m_n)) % 256;
                done = 1;
                m_q.delete();
                m_n = clamp(ns);
            end
        end
        if (done) begin
            if (!m_valid || ack) begin
                m_data = cand;
                m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (ack) begin
            m_valid = 0;
        end
        if (m_ena_prev && !e) m_ovr = 0;
        m_ena_prev = e;
    endtask

    // One clock: drive inputs, step the model at the edge, optionally compare.
    task automatic cycle(input bit e, input bit sv, input logic [7:0] d,
                         input logic [2:0] ns, input bit ack, input bit mchk);
        ena = e; smp_valid = sv; smp_data = d; nsel = ns; res_ack = ack;
        @(posedge clk);
        model_step(e, sv, int'(d), int'(ns), ack);
        #1;
        smp_valid = 0; res_ack = 0;
        if (mchk) begin
            chk("rnd_res_data", res_data, m_data);
            chk("rnd_res_valid", res_valid, m_valid);
            chk("rnd_overrun", overrun, m_ovr);
            chk("rnd_busy", busy, m_active);
        end
    endtask

    task automatic smp(input logic [7:0] d, input logic [2:0] ns, input bit ack);
        cycle(1, 1, d, ns, ack, 0);
    endtask

    task automatic restart(input logic [2:0] ns, input bit ack);
        cycle(0, 0, 8'd0, ns, ack, 0);
        cycle(1, 0, 8'd0, ns, 0, 0);
    endtask

    typedef struct {
        bit e; bit sv; logic [7:0] d; logic [2:0] ns; bit ack;
        int xd; bit xv; bit xo; bit xb;
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{1, 0, 8'd0,   3'd2, 0, 0,   0, 0, 1};
        tbl[1] = '{1, 1, 8'd10,  3'd2, 0, 0,   0, 0, 1};
        tbl[2] = '{1, 1, 8'd11,  3'd2, 0, 0,   0, 0, 1};
        tbl[3] = '{1, 1, 8'd12,  3'd2, 0, 0,   0, 0, 1};
        tbl[4] = '{1, 1, 8'd13,  3'd0, 0, 11,  1, 0, 1};
        tbl[5] = '{1, 0, 8'd0,   3'd0, 1, 11,  0, 0, 1};
        tbl[6] = '{1, 1, 8'd200, 3'd0, 0, 200, 1, 0, 1};
        tbl[7] = '{1, 0, 8'd0,   3'd0, 1, 200, 0, 0, 1};
        tbl[8] = '{1, 1, 8'd7,   3'd0, 0, 7,   1, 0, 1};
        tbl[9] = '{1, 0, 8'd0,   3'd0, 1, 7,   0, 0, 1};

        rst_n = 0; ena = 0; smp_valid = 0; smp_data = 0; nsel = 0; res_ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_res_data", res_data, 0);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_busy", busy, 0);
        rst_n = 1;

        // Averaging at nsel=2, then nsel=0 pass-through with acks.
        foreach (tbl[i]) begin
            cycle(tbl[i].e, tbl[i].sv, tbl[i].d, tbl[i].ns, tbl[i].ack, 0);
            chk($sformatf("vec%0d_res_data", i), res_data, tbl[i].xd);
            chk($sformatf("vec%0d_res_valid", i), res_valid, tbl[i].xv);
            chk($sformatf("vec%0d_overrun", i), overrun, tbl[i].xo);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].xb);
        end

        // nsel=4 with full-scale samples: the accumulator must not wrap.
        restart(3'd4, 0);
        for (int i = 0; i < 15; i++) smp(8'd255, 3'd4, 0);
        chk("max_pre_valid", res_valid, 0);
        smp(8'd255, 3'd4, 0);
        chk("max_res_valid", res_valid, 1);
        chk("max_res_data", res_data, 255);

        // Overrun when unread, then ack coincident with completion.
        restart(3'd1, 1);
        smp(8'd4, 3'd1, 0);
        smp(8'd6, 3'd1, 0);
        chk("ovr_first_data", res_data, 5);
        smp(8'd8, 3'd1, 0);
        smp(8'd10, 3'd1, 0);
        chk("ovr_flag", overrun, 1);
        chk("ovr_data_held", res_data, 5);
        smp(8'd20, 3'd1, 0);
        smp(8'd22, 3'd1, 1);
        chk("ackdone_data", res_data, 21);
        chk("ackdone_valid", res_valid, 1);
        chk("ackdone_ovr_kept", overrun, 1);

        // Partial block discarded by ena drop; ena falling edge clears overrun.
        restart(3'd2, 1);
        chk("ena_fall_ovr_clr", overrun, 0);
        smp(8'd50, 3'd2, 0);
        smp(8'd60, 3'd2, 0);
        smp(8'd70, 3'd2, 0);
        cycle(0, 0, 8'd0, 3'd2, 0, 0);
        chk("ena_low_busy", busy, 0);
        cycle(1, 0, 8'd0, 3'd2, 0, 0);
        for (int i = 0; i < 4; i++) smp(8'd1, 3'd2, 0);
        chk("flush_res_data", res_data, 1);
        chk("flush_res_valid", res_valid, 1);

        // Asynchronous reset in the middle of a block.
        restart(3'd2, 1);
        for (int i = 0; i < 3; i++) smp(8'd100, 3'd2, 0);
        ena = 0;
        #2 rst_n = 0;
        #1;
        chk("arst_res_data", res_data, 0);
        chk("arst_res_valid", res_valid, 0);
        chk("arst_overrun", overrun, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1;
        model_reset();
        cycle(1, 0, 8'd0, 3'd2, 0, 0);
        for (int i = 0; i < 4; i++) smp(8'd4, 3'd2, 0);
        chk("arst_fresh_data", res_data, 4);
        chk("arst_fresh_valid", res_valid, 1);

        // Random traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom % 24) != 0, $urandom % 2, 8'($urandom),
                  3'($urandom_range(0, 7)), ($urandom % 4) == 0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
